// File: rtl/alu_pkg.sv
// Shared ALU constants and the sequential divider state encoding.
package alu_pkg;

  localparam int unsigned WIDTH = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } div_state_e;

  localparam logic [WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/subtractor.sv
// Plain unsigned subtractor; wraps on underflow and exposes no borrow.
module subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff
);

  assign diff = a - b;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, MSB first.
module seq_divider #(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  import alu_pkg::*;

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e       state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] dvs_q;

  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] d_nxt;

  // R stays below 2^(WIDTH-1) before each shift, so r_sh never loses a bit.
  assign r_sh = {r_q[WIDTH-2:0], d_q[WIDTH-1]};

  subtractor #(
    .WIDTH(WIDTH)
  ) u_sub (
    .a   (r_sh),
    .b   (dvs_q),
    .diff(diff)
  );

  always_comb begin
    ge    = (r_sh >= dvs_q);
    r_nxt = ge ? diff : r_sh;
    d_nxt = {d_q[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      r_q         <= '0;
      d_q         <= '0;
      dvs_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            r_q   <= '0;
            cnt_q <= '0;
            d_q   <= dividend;
            dvs_q <= divisor;
            if (divisor == '0) begin
              state_q     <= StDone;
              busy        <= 1'b0;
              done        <= 1'b1;
              quotient    <= WIDTH'(DIV0_QUOT);
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state_q <= StRun;
              busy    <= 1'b1;
              done    <= 1'b0;
            end
          end else begin
            state_q <= StIdle;
            done    <= 1'b0;
          end
        end
        StRun: begin
          r_q   <= r_nxt;
          d_q   <= d_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_q     <= StDone;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= d_nxt;
            remainder   <= r_nxt;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver queues expected results, monitor checks on done.
module tb_seq_divider;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  seq_divider dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done cycle consumes one scoreboard entry.
  always @(posedge clk) begin
    #1;
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", int'(quotient), int'(e.q));
        chk("remainder", int'(remainder), int'(e.r));
        chk("div_by_zero", int'(div_by_zero), int'(e.dz));
      end
    end
  end

  // Restoring-division invariant after each iteration edge.
  always @(posedge clk) begin
    logic pre_busy;
    pre_busy = busy;
    #1;
    if (pre_busy && rst_n) chk("r_lt_divisor", int'(dut.r_q < dut.dvs_q), 1);
  end

  // Called at a negedge; leaves start low at the following negedge.
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] q,
                       input logic [3:0] r, input logic dz, input bit push);
    exp_t e;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.q = q;
    e.r = r;
    e.dz = dz;
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (b != 4'd0) begin
      chk("busy_after_start", int'(busy), 1);
      chk("done_after_start", int'(done), 0);
    end
  endtask

  task automatic wait_done(input int exp_lat);
    int n;
    int nb;
    n  = 0;
    nb = 0;
    while (!done && n < 20) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    chk("done_latency", n, exp_lat);
    chk("busy_cycles", nb, exp_lat);
    chk("busy_at_done", int'(busy), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_div_by_zero", int'(div_by_zero), 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 1'b1);
    wait_done(4);
    @(negedge clk);
    issue(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1'b1);
    wait_done(4);
    @(negedge clk);
    issue(4'd3, 4'd9, 4'd0, 4'd3, 1'b0, 1'b1);
    wait_done(4);
    @(negedge clk);
    issue(4'd15, 4'd9, 4'd1, 4'd6, 1'b0, 1'b1);
    wait_done(4);
    @(negedge clk);
    issue(4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b1);
    wait_done(4);
    @(negedge clk);

    // Divide by zero: done the cycle after start, busy never set.
    issue(4'd7, 4'd0, 4'hF, 4'd7, 1'b1, 1'b1);
    wait_done(0);
    @(negedge clk);
    chk("div0_done_drops", int'(done), 0);

    // Start during RUN with new operands is ignored.
    issue(4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 1'b1);
    @(negedge clk);
    dividend = 4'd9;
    divisor  = 4'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2);
    @(negedge clk);

    // Async reset mid-RUN abandons the operation.
    issue(4'd13, 4'd4, 4'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_quotient", int'(quotient), 0);
    chk("midrst_remainder", int'(remainder), 0);
    chk("midrst_div_by_zero", int'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    issue(4'd10, 4'd3, 4'd3, 4'd1, 1'b0, 1'b1);
    wait_done(4);

    // Back-to-back: start issued in the DONE cycle.
    @(negedge clk);
    issue(4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 1'b1);
    wait_done(4);
    issue(4'd12, 4'd5, 4'd2, 4'd2, 1'b0, 1'b1);
    wait_done(4);
    @(negedge clk);

    // Full sweep, non-zero divisors, against the language operators.
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        issue(4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0, 1'b1);
        wait_done(4);
      end
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
